// File: rtl/vector_seq.sv
// vector_seq: command sequencer for a vector-display line engine.
//
// Commands (move / draw / home / nop with a 10-bit target point) are queued
// in a FIFO_DEPTH-entry FIFO. In IDLE the head command is popped and acted on.
// Move and home only update the beam position. Draw latches the current
// position as the segment start and the target as the segment end, then runs
// ISSUE -> WAIT_START -> WAIT_DONE -> SETTLE around the line engine handshake.
//
// Ports:
//   pclk, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready = FIFO not full)
//   cmd_op, cmd_x, cmd_y    00 move, 01 draw, 10 home, 11 nop; target point
//   ld_go                   one-cycle start pulse to the line engine
//   ld_busy                 line engine busy
//   ld_stax/stay/endx/endy  segment endpoints, stable ISSUE..SETTLE
//   idle                    FIFO empty and FSM in IDLE
//   seg_count               number of draws issued (wraps at 16 bits)
//   err                     sticky watchdog flag
//
// Optional feature: define VECTOR_SEQ_WATCHDOG_EN to add a 12-bit watchdog
// that aborts a stuck segment after 4095 wait cycles and sets err. Without
// it err is tied low and the wait states wait indefinitely.
module vector_seq #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [9:0] HOME_X     = 10'd512,
  parameter logic [9:0] HOME_Y     = 10'd512
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  output logic        ld_go,
  input  logic        ld_busy,
  output logic [9:0]  ld_stax,
  output logic [9:0]  ld_stay,
  output logic [9:0]  ld_endx,
  output logic [9:0]  ld_endy,
  output logic        idle,
  output logic [15:0] seg_count,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_HOME = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_SETTLE
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [21:0] mem_q [FIFO_DEPTH];
  logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]  stax_q, stax_d, stay_q, stay_d, endx_q, endx_d, endy_q, endy_d;
  logic [15:0] seg_q, seg_d;
  logic        full, empty, push, pop;
  logic [1:0]  head_op;
  logic [9:0]  head_x, head_y;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign {head_op, head_x, head_y} = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_x, cmd_y};
  end

`ifdef VECTOR_SEQ_WATCHDOG_EN
  logic [11:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  // State and datapath registers
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pos_x_q  <= HOME_X;
      pos_y_q  <= HOME_Y;
      stax_q   <= '0;
      stay_q   <= '0;
      endx_q   <= '0;
      endy_q   <= '0;
      seg_q    <= '0;
`ifdef VECTOR_SEQ_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      stax_q   <= stax_d;
      stay_q   <= stay_d;
      endx_q   <= endx_d;
      endy_q   <= endy_d;
      seg_q    <= seg_d;
`ifdef VECTOR_SEQ_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    stax_d   = stax_q;
    stay_d   = stay_q;
    endx_d   = endx_q;
    endy_d   = endy_q;
    seg_d    = seg_q;
`ifdef VECTOR_SEQ_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          unique case (head_op)
            OP_MOVE: begin
              pos_x_d = head_x;
              pos_y_d = head_y;
            end
            OP_DRAW: begin
              stax_d  = pos_x_q;
              stay_d  = pos_y_q;
              endx_d  = head_x;
              endy_d  = head_y;
              pos_x_d = head_x;
              pos_y_d = head_y;
              state_d = S_ISSUE;
            end
            OP_HOME: begin
              pos_x_d = HOME_X;
              pos_y_d = HOME_Y;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        seg_d   = seg_q + 16'd1;
        state_d = S_WAIT_START;
`ifdef VECTOR_SEQ_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_START: if (ld_busy)  state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (!ld_busy) state_d = S_SETTLE;
      S_SETTLE:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
`ifdef VECTOR_SEQ_WATCHDOG_EN
    // Watchdog overrides the handshake once the wait has run 4095 cycles.
    if (state_q == S_WAIT_START || state_q == S_WAIT_DONE) begin
      if (wd_q == 12'hFFF) begin
        err_d   = 1'b1;
        state_d = S_SETTLE;
      end else begin
        wd_d = wd_q + 12'd1;
      end
    end
`endif
  end

  // Outputs
  always_comb begin
    ld_go     = (state_q == S_ISSUE);
    idle      = empty && (state_q == S_IDLE);
    cmd_ready = !full;
    ld_stax   = stax_q;
    ld_stay   = stay_q;
    ld_endx   = endx_q;
    ld_endy   = endy_q;
    seg_count = seg_q;
  end

`ifdef VECTOR_SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
